sram_1rw_wmask_param: RTL and testbench

//  Parametrised single-port (1rw) synchronous SRAM, successor to the fixed 32x128 macro model.

---
 rtl/sram_1rw_wmask_param.sv | 118 +++++++++++
 tb/tb_sram_1rw_wmask_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_wmask_param.sv
// Single-port synchronous SRAM with byte write mask, 1/2-cycle read
// latency and a post-reset clear sweep that gates accesses via ready0.
module sram_1rw_wmask_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk0,
  input  logic                             rst0_n,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dout_vld0,
  output logic                             ready0
);

  localparam int WMASK_WIDTH = DATA_WIDTH / BYTE_WIDTH;
  localparam int RAM_DEPTH   = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 ||
      (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_bad_cfg
    $error("sram_1rw_wmask_param: illegal parameter set");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic                    acc;
  logic                    rd;
  logic                    wr;

  assign acc = ready0 & ~csb0;
  assign rd  = acc & web0;
  assign wr  = acc & ~web0;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state  <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      ready0 <= (CLEAR_ON_RESET == 0);
      ptr    <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (&ptr) begin
            state  <= READY;
            ready0 <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        READY: begin
          ready0 <= 1'b1;
        end
        default: begin
          state <= READY;
        end
      endcase
    end
  end

  // Array is never reset; the sweep owns the port until it finishes.
  always_ff @(posedge clk0) begin
    if (state == CLEAR) begin
      mem[ptr] <= CLEAR_VALUE;
    end else if (wr) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            din0[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
        dout0     <= '0;
        dout_vld0 <= 1'b0;
      end else begin
        dout_vld0 <= rd;
        if (rd) begin
          dout0 <= mem[addr0];
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_v;

    always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
        rd_q      <= '0;
        rd_v      <= 1'b0;
        dout0     <= '0;
        dout_vld0 <= 1'b0;
      end else begin
        rd_v      <= rd;
        dout_vld0 <= rd_v;
        if (rd) begin
          rd_q <= mem[addr0];
        end
        if (rd_v) begin
          dout0 <= rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_1rw_wmask_param.sv
// Directed bench: latency-1 and latency-2 32x128 instances share stimulus
// and a queue-based model; a 64x16 instance checks width/clear value.
module tb_sram_1rw_wmask_param;

  logic        clk0 = 1'b0;
  logic        rst0_n = 1'b0;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [6:0]  addr0 = '0;
  logic [31:0] din0 = '0;

  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, ready_a, ready_b;

  logic        c_csb = 1'b1;
  logic        c_web = 1'b1;
  logic [7:0]  c_mask = '0;
  logic [3:0]  c_addr = '0;
  logic [63:0] c_din = '0;
  logic [63:0] c_dout;
  logic        c_vld, c_ready;

  localparam logic [63:0] A5 = {8{8'hA5}};

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  always #5 clk0 = ~clk0;

  sram_1rw_wmask_param #(.READ_LATENCY(1)) u_a (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .web0(web0),
    .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout_a), .dout_vld0(vld_a), .ready0(ready_a)
  );

  sram_1rw_wmask_param #(.READ_LATENCY(2)) u_b (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .web0(web0),
    .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout_b), .dout_vld0(vld_b), .ready0(ready_b)
  );

  sram_1rw_wmask_param #(
    .DATA_WIDTH(64), .ADDR_WIDTH(4), .CLEAR_VALUE(A5)
  ) u_c (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(c_csb), .web0(c_web),
    .wmask0(c_mask), .addr0(c_addr), .din0(c_din),
    .dout0(c_dout), .dout_vld0(c_vld), .ready0(c_ready)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: accesses open once 128 edges have passed since release;
  // read data is queued with the edge at which it must appear.
  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  logic [31:0] mm [128];
  rd_t         qa[$];
  rd_t         qb[$];
  rd_t         t;
  int          rel = 0;
  int          cyc = 0;
  logic [31:0] ea_d = '0;
  logic [31:0] eb_d = '0;
  logic        ea_v = 1'b0;
  logic        eb_v = 1'b0;

  always @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rel = 0;
      qa.delete();
      qb.delete();
      ea_d = '0;
      eb_d = '0;
      ea_v = 1'b0;
      eb_v = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (rel >= 128 && !csb0) begin
        if (web0) begin
          t.d = mm[addr0];
          t.due = cyc;
          qa.push_back(t);
          t.due = cyc + 1;
          qb.push_back(t);
        end else begin
          for (int i = 0; i < 4; i++)
            if (wmask0[i]) mm[addr0][8*i +: 8] = din0[8*i +: 8];
        end
      end
      ea_v = 1'b0;
      eb_v = 1'b0;
      if (qa.size() > 0 && qa[0].due == cyc) begin
        t = qa.pop_front();
        ea_v = 1'b1;
        ea_d = t.d;
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        t = qb.pop_front();
        eb_v = 1'b1;
        eb_d = t.d;
      end
      if (rel < 128) begin
        rel = rel + 1;
        if (rel == 128)
          for (int i = 0; i < 128; i++) mm[i] = '0;
      end
    end
  end

  always @(negedge clk0) begin
    if (run) begin
      check("ready_a", 64'(ready_a), 64'(rel >= 128));
      check("ready_b", 64'(ready_b), 64'(rel >= 128));
      check("vld_a", 64'(vld_a), 64'(ea_v));
      check("vld_b", 64'(vld_b), 64'(eb_v));
      check("dout_a", 64'(dout_a), 64'(ea_d));
      check("dout_b", 64'(dout_b), 64'(eb_d));
    end
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic op(input logic c, input logic w, input logic [3:0] m,
                    input logic [6:0] a, input logic [31:0] d);
    csb0 = c;
    web0 = w;
    wmask0 = m;
    addr0 = a;
    din0 = d;
    tick();
    csb0 = 1'b1;
    web0 = 1'b1;
  endtask

  task automatic c_op(input logic w, input logic [7:0] m,
                      input logic [3:0] a, input logic [63:0] d);
    c_csb = 1'b0;
    c_web = w;
    c_mask = m;
    c_addr = a;
    c_din = d;
    tick();
    c_csb = 1'b1;
    c_web = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_a && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic reset_pulse();
    rst0_n = 1'b0;
    tick();
    rst0_n = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    run = 1'b1;
    check("rst_dout_a", 64'(dout_a), 64'h0);
    check("rst_vld_b", 64'(vld_b), 64'h0);
    check("rst_ready_a", 64'(ready_a), 64'h0);

    // sweep timing for both geometries
    rst0_n = 1'b1;
    repeat (15) tick();
    check("c_ready_15", 64'(c_ready), 64'h0);
    tick();
    check("c_ready_16", 64'(c_ready), 64'h1);
    wait_ready(n);
    check("ready_cycles", 64'(n + 16), 64'd128);
    op(1'b0, 1'b1, 4'h0, 7'd0, '0);
    check("rd0", 64'(dout_a), 64'h0);
    op(1'b0, 1'b1, 4'h0, 7'd64, '0);
    check("rd64", 64'(dout_a), 64'h0);
    op(1'b0, 1'b1, 4'h0, 7'd127, '0);
    check("rd127", 64'(dout_a), 64'h0);
    check("rd127_vld", 64'(vld_a), 64'h1);

    // 64-bit instance: clear value and top-lane mask
    for (int i = 0; i < 16; i++) begin
      c_op(1'b1, 8'h00, 4'(i), '0);
      check("c_clr", c_dout, A5);
    end
    c_op(1'b0, 8'h80, 4'd15, 64'h1122334455667788);
    check("c_wr_novld", 64'(c_vld), 64'h0);
    c_op(1'b1, 8'h00, 4'd15, '0);
    check("c_mask80", c_dout, 64'h11A5A5A5A5A5A5A5);
    check("c_vld", 64'(c_vld), 64'h1);

    // full and partial mask writes
    op(1'b0, 1'b0, 4'hF, 7'd10, 32'hFACECAFE);
    check("wr_novld", 64'(vld_a), 64'h0);
    op(1'b0, 1'b1, 4'h0, 7'd10, '0);
    check("rd10_a", 64'(dout_a), 64'hFACECAFE);
    tick();
    check("rd10_b", 64'(dout_b), 64'hFACECAFE);
    check("rd10_vld_a_gone", 64'(vld_a), 64'h0);
    op(1'b0, 1'b0, 4'b0101, 7'd10, 32'h12345678);
    op(1'b0, 1'b1, 4'h0, 7'd10, '0);
    check("rd10_mask", 64'(dout_a), 64'hFA34CA78);

    // back-to-back reads
    op(1'b0, 1'b0, 4'hF, 7'd1, 32'h11);
    op(1'b0, 1'b0, 4'hF, 7'd2, 32'h22);
    op(1'b0, 1'b0, 4'hF, 7'd3, 32'h33);
    csb0 = 1'b0;
    web0 = 1'b1;
    addr0 = 7'd1;
    tick();
    check("b2b_a1", 64'(dout_a), 64'h11);
    addr0 = 7'd2;
    tick();
    check("b2b_a2", 64'(dout_a), 64'h22);
    check("b2b_b1", 64'(dout_b), 64'h11);
    addr0 = 7'd3;
    tick();
    csb0 = 1'b1;
    check("b2b_a3", 64'(dout_a), 64'h33);
    check("b2b_b2", 64'(dout_b), 64'h22);
    tick();
    check("b2b_b3", 64'(dout_b), 64'h33);
    check("b2b_b3_vld", 64'(vld_b), 64'h1);
    check("b2b_a_hold", 64'(dout_a), 64'h33);

    // request during sweep is dropped; deselected write ignored
    reset_pulse();
    tick();
    tick();
    op(1'b0, 1'b0, 4'hF, 7'd5, 32'hDEAD);
    wait_ready(n);
    check("ready_after_drop", 64'(n + 3), 64'd128);
    op(1'b0, 1'b1, 4'h0, 7'd5, '0);
    check("rd5_dropped", 64'(dout_a), 64'h0);
    op(1'b1, 1'b0, 4'hF, 7'd5, 32'hBEEF);
    check("csb_novld", 64'(vld_a), 64'h0);
    op(1'b0, 1'b1, 4'h0, 7'd5, '0);
    check("rd5_csb", 64'(dout_a), 64'h0);

    // reset mid-sweep, then reset with a latency-2 read in flight
    reset_pulse();
    repeat (49) tick();
    rst0_n = 1'b0;
    #1;
    check("midsweep_ready", 64'(ready_a), 64'h0);
    tick();
    rst0_n = 1'b1;
    wait_ready(n);
    check("ready_resweep", 64'(n), 64'd128);
    op(1'b0, 1'b0, 4'hF, 7'd7, 32'h77);
    op(1'b0, 1'b1, 4'h0, 7'd7, '0);
    check("rd7_a", 64'(dout_a), 64'h77);
    rst0_n = 1'b0;
    #1;
    check("midrd_dout_b", 64'(dout_b), 64'h0);
    check("midrd_vld_b", 64'(vld_b), 64'h0);
    tick();
    check("midrd_vld_b2", 64'(vld_b), 64'h0);
    rst0_n = 1'b1;
    wait_ready(n);
    check("ready_after_rd_rst", 64'(n), 64'd128);
    repeat (3) tick();

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
